hazard_ctrl: RTL and testbench
==============================

// Module: hazard_ctrl
// PURPOSE
//  Pipeline sequencing controller for the 5-stage core; companion to the operand forwarding unit.
//  Detects the load-use hazards that forwarding cannot cover, branch-taken flushes and multi-cycle
//  data-memory waits, and drives per-stage write-enable / flush controls. Tracks memory-wait timeout
//  (sticky error) and saturating stall/flush performance counters. Sits in the core top beside forwarding.
// PARAMETERS
//  MEM_TIMEOUT  256  max consecutive MEM_WAIT cycles before entering ERR
//  CNT_W        32   width of perf counters stall_cnt / flush_cnt
// PORTS
//  clk            in   1      core clock, rising edge
//  rst            in   1      asynchronous, active-high reset
//  if_id_rs1      in   5      rs1 of instruction in ID
//  if_id_rs2      in   5      rs2 of instruction in ID
//  if_id_use_rs1  in   1      ID instruction reads rs1
//  if_id_use_rs2  in   1      ID instruction reads rs2
//  id_ex_mem_read in   1      instruction in EX is a load
//  id_ex_rd       in   5      destination reg of instruction in EX
//  branch_taken   in   1      EX resolved a taken branch/jump (redirect)
//  mem_req        in   1      MEM stage has an active data-memory access
//  mem_ready      in   1      data memory completes access this cycle
//  pc_write       out  1      PC register write enable
//  if_id_write    out  1      IF/ID register write enable
//  if_id_flush    out  1      IF/ID register load NOP
//  id_ex_write    out  1      ID/EX register write enable
//  id_ex_flush    out  1      ID/EX register load bubble
//  ex_mem_write   out  1      EX/MEM register write enable
//  mem_wb_bubble  out  1      MEM/WB loads bubble (no writeback)
//  mem_timeout    out  1      sticky: memory wait exceeded MEM_TIMEOUT
//  stall_cnt      out  CNT_W  cycles lost to load-use + memory wait (saturating)
//  flush_cnt      out  CNT_W  number of branch flush events (saturating)
// BEHAVIOUR
//  State: RUN, MEM_WAIT, ERR; registered, reset -> RUN. Controls are combinational from state+inputs.
//  Reset: state=RUN, wait_cnt=0, mem_timeout=0, stall_cnt=0, flush_cnt=0.
//  Defaults (RUN, no event): all *_write=1, all flush/bubble=0.
//  mem_busy = mem_req & ~mem_ready.  load_use = id_ex_mem_read & (id_ex_rd!=0) &
//   ((id_ex_rd==if_id_rs1 & if_id_use_rs1) | (id_ex_rd==if_id_rs2 & if_id_use_rs2)).
//  Priority each cycle: ERR > mem_busy > branch_taken > load_use.
//  Freeze (mem_busy or ERR): pc_write=if_id_write=id_ex_write=ex_mem_write=0, mem_wb_bubble=1, flushes=0.
//  Branch (RUN, !mem_busy): pc_write=1, if_id_flush=1, id_ex_flush=1; flush_cnt+=1.
//  Load-use (RUN, no branch/busy): pc_write=0, if_id_write=0, id_ex_flush=1; one bubble, stall_cnt+=1.
//  Branch/load-use seen during freeze are held by frozen regs and acted on the first unfrozen cycle.
//  RUN -> MEM_WAIT when mem_busy; wait_cnt<=1; stall_cnt+=1.
//  MEM_WAIT: freeze while mem_busy, stall_cnt+=1/cycle, wait_cnt+=1. mem_ready (or mem_req drop) ->
//   that cycle unfrozen (normal RUN decode applies), next state RUN, wait_cnt<=0.
//  MEM_WAIT with wait_cnt==MEM_TIMEOUT and still busy -> ERR; mem_timeout<=1.
//  ERR: frozen permanently, counters hold; exit only via rst.
//  Counters saturate at all-ones, never wrap. rst asserted mid-wait/mid-stall clears all immediately.
//  No output latency: controls valid in same cycle as the inputs that cause them.
// TESTING
//  EX load rd=5, ID use rs1=5 -> 1 cycle pc_write=0,if_id_write=0,id_ex_flush=1; stall_cnt=1.
//  EX load rd=0, ID rs1=0 used -> no stall (x0 exempt); all writes 1.
//  branch_taken=1 with load_use=1 -> if_id_flush=id_ex_flush=1, pc_write=1; flush_cnt=1, stall_cnt=0.
//  mem_req=1, mem_ready low 3 cycles then high -> 3 frozen cycles, mem_wb_bubble=1, stall_cnt=3, RUN.
//  mem_req=1, mem_ready=0 for MEM_TIMEOUT+1 cycles -> mem_timeout=1, frozen until rst; rst clears all.
//  CNT_W=4, 20 load-use stalls -> stall_cnt holds 4'hF.

Source files
------------

// File: rtl/hazard_ctrl.sv
// Pipeline sequencing controller: load-use stalls, branch flushes and data-memory wait freezes,
// with a sticky memory-timeout error and saturating stall/flush counters.
module hazard_ctrl #(
  parameter int MEM_TIMEOUT = 256,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       i_if_id_rs1,
  input  logic [4:0]       i_if_id_rs2,
  input  logic             i_if_id_use_rs1,
  input  logic             i_if_id_use_rs2,
  input  logic             i_id_ex_mem_read,
  input  logic [4:0]       i_id_ex_rd,
  input  logic             i_branch_taken,
  input  logic             i_mem_req,
  input  logic             i_mem_ready,
  output logic             o_pc_write,
  output logic             o_if_id_write,
  output logic             o_if_id_flush,
  output logic             o_id_ex_write,
  output logic             o_id_ex_flush,
  output logic             o_ex_mem_write,
  output logic             o_mem_wb_bubble,
  output logic             o_mem_timeout,
  output logic [CNT_W-1:0] o_stall_cnt,
  output logic [CNT_W-1:0] o_flush_cnt
);

  // state    | meaning
  // S_RUN    | normal flow; hazards decoded each cycle
  // S_MEM_WAIT | data memory busy, pipeline frozen, wait_cnt counting
  // S_ERR    | memory wait timed out; frozen until reset
  typedef enum logic [1:0] {
    S_RUN      = 2'd0,
    S_MEM_WAIT = 2'd1,
    S_ERR      = 2'd2
  } state_t;

  localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);

  state_t              r_state;
  state_t              w_next_state;
  logic [WAIT_W-1:0]   r_wait_cnt;
  logic                r_mem_timeout;
  logic [CNT_W-1:0]    r_stall_cnt;
  logic [CNT_W-1:0]    r_flush_cnt;

  logic w_mem_busy;
  logic w_load_use;
  logic w_frozen;
  logic w_branch_act;
  logic w_lu_act;
  logic w_timeout_hit;
  logic w_stall_inc;
  logic w_flush_inc;

  assign w_mem_busy = i_mem_req & ~i_mem_ready;

  // x0 is hardwired zero, so a load targeting it never creates a dependency
  assign w_load_use = i_id_ex_mem_read & (i_id_ex_rd != 5'd0) &
                      (((i_id_ex_rd == i_if_id_rs1) & i_if_id_use_rs1) |
                       ((i_id_ex_rd == i_if_id_rs2) & i_if_id_use_rs2));

  assign w_frozen      = (r_state == S_ERR) | w_mem_busy;
  assign w_branch_act  = ~w_frozen & i_branch_taken;
  assign w_lu_act      = ~w_frozen & ~i_branch_taken & w_load_use;
  assign w_timeout_hit = (r_state == S_MEM_WAIT) & w_mem_busy &
                         (r_wait_cnt == WAIT_W'(MEM_TIMEOUT));
  assign w_stall_inc   = (r_state != S_ERR) & (w_mem_busy | w_lu_act);
  assign w_flush_inc   = w_branch_act;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_RUN;
    else     r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_RUN: begin
        if (w_mem_busy) w_next_state = S_MEM_WAIT;
      end
      S_MEM_WAIT: begin
        if (w_timeout_hit)    w_next_state = S_ERR;
        else if (!w_mem_busy) w_next_state = S_RUN;
      end
      S_ERR:   w_next_state = S_ERR;
      default: w_next_state = S_RUN;
    endcase
  end

  always_comb begin
    o_pc_write      = 1'b1;
    o_if_id_write   = 1'b1;
    o_if_id_flush   = 1'b0;
    o_id_ex_write   = 1'b1;
    o_id_ex_flush   = 1'b0;
    o_ex_mem_write  = 1'b1;
    o_mem_wb_bubble = 1'b0;
    if (w_frozen) begin
      o_pc_write      = 1'b0;
      o_if_id_write   = 1'b0;
      o_id_ex_write   = 1'b0;
      o_ex_mem_write  = 1'b0;
      o_mem_wb_bubble = 1'b1;
    end else if (w_branch_act) begin
      o_if_id_flush = 1'b1;
      o_id_ex_flush = 1'b1;
    end else if (w_lu_act) begin
      o_pc_write    = 1'b0;
      o_if_id_write = 1'b0;
      o_id_ex_flush = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wait_cnt <= '0;
    end else begin
      case (r_state)
        S_RUN:      if (w_mem_busy) r_wait_cnt <= WAIT_W'(1);
        S_MEM_WAIT: begin
          if (!w_mem_busy)        r_wait_cnt <= '0;
          else if (!w_timeout_hit) r_wait_cnt <= r_wait_cnt + WAIT_W'(1);
        end
        default:    r_wait_cnt <= r_wait_cnt;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                r_mem_timeout <= 1'b0;
    else if (w_timeout_hit) r_mem_timeout <= 1'b1;
  end

  // Counters stick at all-ones rather than wrapping
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      if (w_stall_inc && (r_stall_cnt != {CNT_W{1'b1}}))
        r_stall_cnt <= r_stall_cnt + CNT_W'(1);
      if (w_flush_inc && (r_flush_cnt != {CNT_W{1'b1}}))
        r_flush_cnt <= r_flush_cnt + CNT_W'(1);
    end
  end

  assign o_mem_timeout = r_mem_timeout;
  assign o_stall_cnt   = r_stall_cnt;
  assign o_flush_cnt   = r_flush_cnt;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl: a behavioural model pushes expected controls/counters per cycle into a
// scoreboard queue; entries are popped and compared as the DUT responds.
module tb_hazard_ctrl;

  localparam int TO    = 16;
  localparam int CW    = 4;
  localparam int SATMX = 15;

  logic clk, rst;
  logic [4:0] rs1, rs2, rd;
  logic u1, u2, mr, br, req, rdy;
  logic pc_w, ifid_w, ifid_f, idex_w, idex_f, exmem_w, memwb_b, mto;
  logic [CW-1:0] stall_cnt, flush_cnt;

  int n_cmp = 0;
  int n_err = 0;

  typedef struct {
    logic [6:0] ctrl;
    int         stall;
    int         flush;
    logic       to;
  } exp_t;

  exp_t sb[$];

  int m_state;
  int m_wait;
  int m_stall;
  int m_flush;
  logic m_to;

  hazard_ctrl #(.MEM_TIMEOUT(TO), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst),
    .i_if_id_rs1(rs1), .i_if_id_rs2(rs2),
    .i_if_id_use_rs1(u1), .i_if_id_use_rs2(u2),
    .i_id_ex_mem_read(mr), .i_id_ex_rd(rd),
    .i_branch_taken(br), .i_mem_req(req), .i_mem_ready(rdy),
    .o_pc_write(pc_w), .o_if_id_write(ifid_w), .o_if_id_flush(ifid_f),
    .o_id_ex_write(idex_w), .o_id_ex_flush(idex_f), .o_ex_mem_write(exmem_w),
    .o_mem_wb_bubble(memwb_b), .o_mem_timeout(mto),
    .o_stall_cnt(stall_cnt), .o_flush_cnt(flush_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [6:0] ctrl_vec();
    return {pc_w, ifid_w, ifid_f, idex_w, idex_f, exmem_w, memwb_b};
  endfunction

  task automatic model_reset();
    m_state = 0; m_wait = 0; m_stall = 0; m_flush = 0; m_to = 1'b0;
    sb.delete();
  endtask

  // {pc, if_id_w, if_id_f, id_ex_w, id_ex_f, ex_mem_w, mem_wb_bubble}
  task automatic step(input logic [4:0] a1, input logic [4:0] a2, input logic e1, input logic e2,
                      input logic ld, input logic [4:0] d, input logic b,
                      input logic q, input logic y);
    exp_t e, got_e;
    logic busy, lu, frz;
    rs1 = a1; rs2 = a2; u1 = e1; u2 = e2; mr = ld; rd = d; br = b; req = q; rdy = y;
    busy = q && !y;
    lu   = ld && (d != 0) && (((d == a1) && e1) || ((d == a2) && e2));
    frz  = (m_state == 2) || busy;
    if (frz)    e.ctrl = 7'b0000001;
    else if (b) e.ctrl = 7'b1111110;
    else if (lu) e.ctrl = 7'b0001110;
    else        e.ctrl = 7'b1101010;
    if (m_state != 2) begin
      if (busy) begin
        if (m_stall < SATMX) m_stall++;
        if (m_state == 0) begin
          m_state = 1; m_wait = 1;
        end else if (m_wait == TO) begin
          m_state = 2; m_to = 1'b1;
        end else begin
          m_wait++;
        end
      end else begin
        m_state = 0; m_wait = 0;
        if (b) begin
          if (m_flush < SATMX) m_flush++;
        end else if (lu) begin
          if (m_stall < SATMX) m_stall++;
        end
      end
    end
    e.stall = m_stall; e.flush = m_flush; e.to = m_to;
    sb.push_back(e);
    @(negedge clk);
    got_e = sb.pop_front();
    check_eq("ctrl", {25'd0, ctrl_vec()}, {25'd0, got_e.ctrl});
    @(posedge clk);
    #1;
    check_eq("stall_cnt", {28'd0, stall_cnt}, got_e.stall);
    check_eq("flush_cnt", {28'd0, flush_cnt}, got_e.flush);
    check_eq("mem_timeout", {31'd0, mto}, {31'd0, got_e.to});
  endtask

  task automatic idle();
    step(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
  endtask

  // Asserts reset between clock edges and expects an immediate clear
  task automatic do_reset();
    rst = 1'b1;
    #2;
    check_eq("rst_stall", {28'd0, stall_cnt}, 32'd0);
    check_eq("rst_flush", {28'd0, flush_cnt}, 32'd0);
    check_eq("rst_timeout", {31'd0, mto}, 32'd0);
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    req = 1'b0; rdy = 1'b0; br = 1'b0; mr = 1'b0;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    rs1 = 0; rs2 = 0; u1 = 0; u2 = 0; mr = 0; rd = 0; br = 0; req = 0; rdy = 0;
    model_reset();
    #12;
    check_eq("reset_ctrl", {25'd0, ctrl_vec()}, {25'd0, 7'b1101010});
    check_eq("reset_stall", {28'd0, stall_cnt}, 32'd0);
    check_eq("reset_flush", {28'd0, flush_cnt}, 32'd0);
    check_eq("reset_timeout", {31'd0, mto}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;

    step(5'd5, 5'd7, 1'b1, 1'b1, 1'b1, 5'd5, 1'b0, 1'b0, 1'b0);   // load-use on rs1
    idle();
    step(5'd0, 5'd0, 1'b1, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0);   // x0 exempt
    step(5'd3, 5'd9, 1'b0, 1'b1, 1'b1, 5'd9, 1'b0, 1'b0, 1'b0);   // load-use on rs2
    step(5'd9, 5'd3, 1'b0, 1'b1, 1'b1, 5'd9, 1'b0, 1'b0, 1'b0);   // match but rs not used

    do_reset();
    step(5'd5, 5'd0, 1'b1, 1'b0, 1'b1, 5'd5, 1'b1, 1'b0, 1'b0);   // branch beats load-use
    check_eq("branch_flush_cnt", {28'd0, flush_cnt}, 32'd1);
    check_eq("branch_stall_cnt", {28'd0, stall_cnt}, 32'd0);

    do_reset();
    repeat (3) step(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0);
    step(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1);
    check_eq("memwait_stall_cnt", {28'd0, stall_cnt}, 32'd3);
    idle();

    // branch held across a freeze takes effect on the release cycle
    repeat (2) step(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b1, 1'b0);
    step(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b1, 1'b1);
    // mem_req dropping also ends a wait
    step(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0);
    step(5'd4, 5'd0, 1'b1, 1'b0, 1'b1, 5'd4, 1'b0, 1'b0, 1'b0);

    do_reset();
    for (int i = 0; i < 150; i++) begin
      step(5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
           1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
           1'($urandom_range(0, 1)), 5'($urandom_range(0, 3)),
           1'($urandom_range(0, 3) == 0),
           1'($urandom_range(0, 2) == 0), 1'($urandom_range(0, 1)));
    end

    // rst in the middle of a memory wait
    repeat (2) step(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0);
    do_reset();

    repeat (20) step(5'd6, 5'd0, 1'b1, 1'b0, 1'b1, 5'd6, 1'b0, 1'b0, 1'b0);
    check_eq("stall_saturate", {28'd0, stall_cnt}, 32'hF);

    do_reset();
    repeat (TO + 1) step(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0);
    check_eq("timeout_set", {31'd0, mto}, 32'd1);
    repeat (3) step(5'd2, 5'd0, 1'b1, 1'b0, 1'b1, 5'd2, 1'b1, 1'b1, 1'b1);
    idle();
    do_reset();
    idle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
